// File: rtl/add_serial_n.sv
// add_serial_n: multi-cycle adder/subtractor that processes DIGIT bits per clock,
// LSB first, with a registered carry between digits. A start/busy/done handshake
// lets several arithmetic users share this one small datapath.
//
// Ports
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous active-low reset
//   start     in   1      request; accepted only when busy=0
//   sub       in   1      0: x+y, 1: x-y (two's complement); sampled with start
//   x, y      in   WIDTH  operands; sampled with start
//   busy      out  1      high while a computation is in progress (N cycles)
//   done      out  1      one-cycle pulse; result/retenue/overflow just updated
//   result    out  WIDTH  sum or difference modulo 2^WIDTH
//   retenue   out  1      carry out of the MSB (subtract: 1 = no borrow)
//   overflow  out  1      signed overflow
//
// state  | meaning
// S_IDLE | waiting for start
// S_RUN  | one digit per cycle, N cycles, busy=1
// S_DONE | results valid pulse; start here chains straight into S_RUN

module add_serial_n #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             retenue,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             retenue_q, retenue_d;
  logic             overflow_q, overflow_d;

  logic [DIGIT-1:0] a_dig, b_dig;
  logic [DIGIT:0]   sum_dig;
  logic [WIDTH-1:0] acc_next;

  always_comb begin
    a_dig   = a_q[DIGIT-1:0];
    b_dig   = b_q[DIGIT-1:0];
    sum_dig = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
    // New digit enters from the MSB side; after N shifts the first digit sits at bit 0.
    acc_next = (acc_q >> DIGIT) | (WIDTH'(sum_dig[DIGIT-1:0]) << (WIDTH - DIGIT));

    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    retenue_d  = retenue_q;
    overflow_d = overflow_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          // Subtraction = x + ~y + 1, the +1 enters as the initial carry.
          a_d     = x;
          b_d     = y ^ {WIDTH{sub}};
          carry_d = sub;
          cnt_d   = CNT_LOAD;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d   = acc_next;
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = sum_dig[DIGIT];
        if (cnt_q == '0) begin
          state_d   = S_DONE;
          result_d  = acc_next;
          retenue_d = sum_dig[DIGIT];
          // a^b^s at the MSB recovers the carry into the MSB.
          overflow_d = a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ sum_dig[DIGIT-1] ^ sum_dig[DIGIT];
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      result_q   <= '0;
      retenue_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      retenue_q  <= retenue_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign result   = result_q;
  assign retenue  = retenue_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_add_serial_n.sv
module tb_add_serial_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, sub;
  logic [7:0] x, y;
  logic       busy, done, retenue, overflow;
  logic [7:0] result;

  logic       start4, sub4;
  logic [7:0] x4, y4;
  logic       busy4, done4, retenue4, overflow4;
  logic [7:0] result4;

  add_serial_n #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .x(x), .y(y),
    .busy(busy), .done(done), .result(result), .retenue(retenue), .overflow(overflow)
  );

  add_serial_n #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .x(x4), .y(y4),
    .busy(busy4), .done(done4), .result(result4), .retenue(retenue4), .overflow(overflow4)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] r;
    logic       c;
    logic       ov;
  } exp_t;

  typedef struct {
    logic       s;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic       c;
    logic       ov;
  } vec_t;

  exp_t sb_q[$];

  function automatic exp_t model(input logic s, input logic [7:0] a, input logic [7:0] b);
    exp_t       e;
    logic [7:0] bb;
    logic [8:0] t;
    bb   = s ? ~b : b;
    t    = {1'b0, a} + {1'b0, bb} + {8'd0, s};
    e.r  = t[7:0];
    e.c  = t[8];
    e.ov = (a[7] == bb[7]) && (t[7] != a[7]);
    return e;
  endfunction

  // Scoreboard: every done pulse consumes one expected record.
  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result", {24'd0, result}, {24'd0, e.r});
        check("retenue", {31'd0, retenue}, {31'd0, e.c});
        check("overflow", {31'd0, overflow}, {31'd0, e.ov});
      end
    end
  end

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_op(input logic s, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] er, input logic ec, input logic eov);
    int         lat, bcnt;
    logic [7:0] prev;
    logic       held;
    exp_t       e;
    @(negedge clk);
    start = 1'b1; sub = s; x = a; y = b;
    e.r = er; e.c = ec; e.ov = eov;
    sb_q.push_back(e);
    prev = result;
    held = 1'b1;
    @(negedge clk);
    start = 1'b0; x = 8'($urandom); y = 8'($urandom); sub = 1'($urandom);
    lat = 1; bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      if (result !== prev) held = 1'b0;
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 9);
    check("busy_cycles", bcnt, 8);
    check("result_hold", {31'd0, held}, 32'd1);
  endtask

  task automatic run_d4(input logic s, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] er, input logic ec, input logic eov);
    int lat, bcnt;
    @(negedge clk);
    start4 = 1'b1; sub4 = s; x4 = a; y4 = b;
    @(negedge clk);
    start4 = 1'b0; x4 = 8'($urandom); y4 = 8'($urandom);
    lat = 1; bcnt = 0;
    while (!done4 && lat < 20) begin
      if (busy4) bcnt++;
      @(negedge clk);
      lat++;
    end
    check("d4_latency", lat, 3);
    check("d4_busy_cycles", bcnt, 2);
    check("d4_result", {24'd0, result4}, {24'd0, er});
    check("d4_retenue", {31'd0, retenue4}, {31'd0, ec});
    check("d4_overflow", {31'd0, overflow4}, {31'd0, eov});
    @(negedge clk);
    check("d4_done_pulse", {31'd0, done4}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  vec_t vecs[10];
  int   n;
  int   done_seen;

  initial begin
    vecs[0] = '{1'b0, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 8'h7F, 8'hFF, 8'h80, 1'b0, 1'b1};
    vecs[9] = '{1'b0, 8'h3C, 8'hC3, 8'hFF, 1'b0, 1'b0};

    rst_n = 1'b1; start = 1'b0; sub = 1'b0; x = 8'h00; y = 8'h00;
    start4 = 1'b0; sub4 = 1'b0; x4 = 8'h00; y4 = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", {24'd0, result}, 32'd0);
    check("rst_retenue", {31'd0, retenue}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_d4_result", {24'd0, result4}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++)
      run_op(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].c, vecs[i].ov);

    for (int i = 0; i < 8; i++) begin
      logic [7:0] a, b;
      logic       s;
      exp_t       e;
      a = 8'($urandom); b = 8'($urandom); s = 1'($urandom);
      e = model(s, a, b);
      run_op(s, a, b, e.r, e.c, e.ov);
    end

    // Start during RUN is ignored; start during DONE chains with no idle gap.
    begin
      exp_t e;
      @(negedge clk);
      start = 1'b1; sub = 1'b0; x = 8'h12; y = 8'h34;
      e.r = 8'h46; e.c = 1'b0; e.ov = 1'b0;
      sb_q.push_back(e);
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk); start = 1'b1; sub = 1'b1; x = 8'hAA; y = 8'h11;
      @(negedge clk); start = 1'b0; x = 8'h00; y = 8'h00; sub = 1'b0;
      wait_done(20, n);
      check("t4_latency", n + 4, 9);
      start = 1'b1; sub = 1'b0; x = 8'h7F; y = 8'h01;
      e.r = 8'h80; e.c = 1'b0; e.ov = 1'b1;
      sb_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      check("t4_no_gap_busy", {31'd0, busy}, 32'd1);
      check("t4_done_low", {31'd0, done}, 32'd0);
      wait_done(20, n);
      check("t4_b2b_latency", n + 1, 9);
    end

    // Reset in the middle of a run.
    @(negedge clk);
    start = 1'b1; sub = 1'b0; x = 8'h33; y = 8'h44;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_busy_before_rst", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_done", {31'd0, done}, 32'd0);
    check("t5_result", {24'd0, result}, 32'd0);
    check("t5_retenue", {31'd0, retenue}, 32'd0);
    check("t5_overflow", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("t5_no_done_after_abort", done_seen, 0);
    run_op(1'b0, 8'h33, 8'h44, 8'h77, 1'b0, 1'b0);

    // DIGIT=4 instance
    run_d4(1'b0, 8'h9C, 8'h77, 8'h13, 1'b1, 1'b0);
    run_d4(1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0);
    run_d4(1'b0, 8'h70, 8'h10, 8'h80, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
